pcie_slv_regs: RTL and testbench

PCIE_SLV_REGS -- requirements
Module: pcie_slv_regs

---
 rtl/pcie_slv_regs.sv | 171 +++++++++++++++++
 tb/tb_pcie_slv_regs.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_slv_regs.sv
`timescale 1ns/1ps
// pcie_slv_regs: PCIe slave register window (BAR0) plus 512x16 scratch RAM (BAR2).
//
// Ports:
//   pcie_clk    - single clock for all logic
//   sys_rst_n   - asynchronous active-low reset
//   slv_bar_i   - BAR hit vector; bit0 = register window, bit2 = scratch RAM (bit0 wins)
//   slv_ce_i    - access strobe
//   slv_we_i    - write qualifier (valid with slv_ce_i)
//   slv_adr_i   - 16-bit word address [19:1]
//   slv_dat_i   - write data
//   slv_sel_i   - byte enables (bit1 -> [15:8], bit0 -> [7:0])
//   slv_dat_o   - read data, registered one cycle after the address
//   dipsw, btn  - asynchronous board inputs, synchronised internally
//   led         - active-low LEDs (~led_reg)
//   segled      - active-low 7-segment pair (~seg_reg)
module pcie_slv_regs #(
    parameter logic [15:0] ID_CODE = 16'h5043,
    parameter logic [15:0] VERSION = 16'h0001
) (
    input  logic        pcie_clk,
    input  logic        sys_rst_n,
    input  logic [6:0]  slv_bar_i,
    input  logic        slv_ce_i,
    input  logic        slv_we_i,
    input  logic [19:1] slv_adr_i,
    input  logic [15:0] slv_dat_i,
    input  logic [1:0]  slv_sel_i,
    output logic [15:0] slv_dat_o,
    input  logic [7:0]  dipsw,
    input  logic        btn,
    output logic [7:0]  led,
    output logic [13:0] segled
);

    logic [15:0] mem_q [512];

    logic [15:0] dat_q, dat_d;
    logic [7:0]  led_q, led_d;
    logic [13:0] seg_q, seg_d;
    logic [15:0] scr_q, scr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic [15:0] wrc_q, wrc_d;
    logic [7:0]  dip_s1_q, dip_s2_q;
    logic        btn_s1_q, btn_s2_q;

    logic        hit_reg, hit_ram;
    logic        reg_wr, ram_wr, acc_wr;
    logic [3:0]  reg_idx;
    logic [8:0]  ram_idx;
    logic [15:0] reg_rdata;

    // Address bits above the RAM index and unused BAR bits play no role.
    logic unused_inputs;
    assign unused_inputs = ^{slv_adr_i[19:10], slv_bar_i[6:3], slv_bar_i[1]};

    assign hit_reg = slv_bar_i[0];
    assign hit_ram = ~slv_bar_i[0] & slv_bar_i[2];
    assign reg_idx = slv_adr_i[4:1];
    assign ram_idx = slv_adr_i[9:1];
    assign reg_wr  = slv_ce_i & slv_we_i & hit_reg;
    assign ram_wr  = slv_ce_i & slv_we_i & hit_ram;
    assign acc_wr  = (reg_wr | ram_wr) & (|slv_sel_i);

    // Register window read mux (combinational, sampled into dat_q every cycle).
    always_comb begin
        reg_rdata = 16'h0000;
        case (reg_idx)
            4'd0:    reg_rdata = ID_CODE;
            4'd1:    reg_rdata = VERSION;
            4'd2:    reg_rdata = {7'h00, btn_s2_q, dip_s2_q};
            4'd3:    reg_rdata = {8'h00, led_q};
            4'd4:    reg_rdata = {2'b00, seg_q};
            4'd5:    reg_rdata = scr_q;
            4'd6:    reg_rdata = snap_q[15:0];
            4'd7:    reg_rdata = snap_q[31:16];
            4'd8:    reg_rdata = wrc_q;
            default: reg_rdata = 16'h0000;
        endcase
    end

    // Reads see the pre-write state because state only updates on the edge.
    always_comb begin
        if (hit_reg) begin
            dat_d = reg_rdata;
        end else if (hit_ram) begin
            dat_d = mem_q[ram_idx];
        end else begin
            dat_d = 16'h0000;
        end
    end

    always_comb begin
        led_d  = led_q;
        seg_d  = seg_q;
        scr_d  = scr_q;
        snap_d = snap_q;
        wrc_d  = wrc_q;
        cnt_d  = cnt_q + 32'd1;

        if (reg_wr) begin
            case (reg_idx)
                4'd3: begin
                    if (slv_sel_i[0]) led_d = slv_dat_i[7:0];
                end
                4'd4: begin
                    if (slv_sel_i[0]) seg_d[7:0]  = slv_dat_i[7:0];
                    if (slv_sel_i[1]) seg_d[13:8] = slv_dat_i[13:8];
                end
                4'd5: begin
                    if (slv_sel_i[0]) scr_d[7:0]  = slv_dat_i[7:0];
                    if (slv_sel_i[1]) scr_d[15:8] = slv_dat_i[15:8];
                end
                // Snapshot fires on any write strobe, regardless of byte enables.
                4'd6:    snap_d = cnt_q;
                default: ;
            endcase
        end

        // Clear wins over the increment the same write would cause.
        if (acc_wr) begin
            if (reg_wr && reg_idx == 4'd8) begin
                wrc_d = 16'h0000;
            end else if (wrc_q != 16'hFFFF) begin
                wrc_d = wrc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dat_q    <= 16'h0000;
            led_q    <= 8'h00;
            seg_q    <= 14'h0000;
            scr_q    <= 16'h0000;
            cnt_q    <= 32'h0000_0000;
            snap_q   <= 32'h0000_0000;
            wrc_q    <= 16'h0000;
            dip_s1_q <= 8'h00;
            dip_s2_q <= 8'h00;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            dat_q    <= dat_d;
            led_q    <= led_d;
            seg_q    <= seg_d;
            scr_q    <= scr_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            wrc_q    <= wrc_d;
            dip_s1_q <= dipsw;
            dip_s2_q <= dip_s1_q;
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
        end
    end

    // Scratch RAM contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge pcie_clk) begin
        if (ram_wr && sys_rst_n) begin
            if (slv_sel_i[0]) mem_q[ram_idx][7:0]  <= slv_dat_i[7:0];
            if (slv_sel_i[1]) mem_q[ram_idx][15:8] <= slv_dat_i[15:8];
        end
    end

    assign slv_dat_o = dat_q;
    assign led       = ~led_q;
    assign segled    = ~seg_q;

endmodule

// File: tb/tb_pcie_slv_regs.sv
`timescale 1ns/1ps
module tb_pcie_slv_regs;

    logic        clk;
    logic        sys_rst_n;
    logic [6:0]  slv_bar_i;
    logic        slv_ce_i;
    logic        slv_we_i;
    logic [19:1] slv_adr_i;
    logic [15:0] slv_dat_i;
    logic [1:0]  slv_sel_i;
    logic [15:0] slv_dat_o;
    logic [7:0]  dipsw;
    logic        btn;
    logic [7:0]  led;
    logic [13:0] segled;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [15:0] m_mem [512];
    logic [7:0]  m_led;
    logic [13:0] m_seg;
    logic [15:0] m_scr;
    logic [31:0] m_snap;
    logic [15:0] m_wrc;
    logic [31:0] m_cnt;

    pcie_slv_regs dut (
        .pcie_clk  (clk),
        .sys_rst_n (sys_rst_n),
        .slv_bar_i (slv_bar_i),
        .slv_ce_i  (slv_ce_i),
        .slv_we_i  (slv_we_i),
        .slv_adr_i (slv_adr_i),
        .slv_dat_i (slv_dat_i),
        .slv_sel_i (slv_sel_i),
        .slv_dat_o (slv_dat_o),
        .dipsw     (dipsw),
        .btn       (btn),
        .led       (led),
        .segled    (segled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since reset release: the value the counter holds during a cycle.
    always @(posedge clk) begin
        if (!sys_rst_n) m_cnt <= 32'd0;
        else            m_cnt <= m_cnt + 32'd1;
    end

    function automatic logic [15:0] model_rd(input logic [6:0] bar, input logic [18:0] a);
        if (bar[0]) begin
            case (a[3:0])
                4'd0: return 16'h5043;
                4'd1: return 16'h0001;
                4'd2: return {7'h00, btn, dipsw};
                4'd3: return {8'h00, m_led};
                4'd4: return {2'b00, m_seg};
                4'd5: return m_scr;
                4'd6: return m_snap[15:0];
                4'd7: return m_snap[31:16];
                4'd8: return m_wrc;
                default: return 16'h0000;
            endcase
        end
        if (bar[2]) return m_mem[a[8:0]];
        return 16'h0000;
    endfunction

    task automatic model_wr(input logic [6:0] bar, input logic [18:0] a,
                            input logic [15:0] d, input logic [1:0] sel);
        if (bar[0]) begin
            if (a[3:0] == 4'd3 && sel[0]) m_led = d[7:0];
            if (a[3:0] == 4'd4 && sel[0]) m_seg[7:0] = d[7:0];
            if (a[3:0] == 4'd4 && sel[1]) m_seg[13:8] = d[13:8];
            if (a[3:0] == 4'd5 && sel[0]) m_scr[7:0] = d[7:0];
            if (a[3:0] == 4'd5 && sel[1]) m_scr[15:8] = d[15:8];
            if (a[3:0] == 4'd6) m_snap = m_cnt;
        end else if (bar[2]) begin
            if (sel[0]) m_mem[a[8:0]][7:0]  = d[7:0];
            if (sel[1]) m_mem[a[8:0]][15:8] = d[15:8];
        end else begin
            return;
        end
        if (sel != 2'b00) begin
            if (bar[0] && a[3:0] == 4'd8) m_wrc = 16'h0000;
            else if (m_wrc < 16'hFFFF)    m_wrc = m_wrc + 16'd1;
        end
    endtask

    // Drive one access at a negedge; exp is the read data that appears after the edge.
    task automatic do_cycle(input logic [6:0] bar, input logic ce, input logic we,
                            input logic [18:0] a, input logic [15:0] d,
                            input logic [1:0] sel, output logic [15:0] exp);
        slv_bar_i = bar;
        slv_ce_i  = ce;
        slv_we_i  = we;
        slv_adr_i = a;
        slv_dat_i = d;
        slv_sel_i = sel;
        exp = model_rd(bar, a);
        if (ce && we) model_wr(bar, a, d, sel);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_led  = 8'h00;
        m_seg  = 14'h0000;
        m_scr  = 16'h0000;
        m_snap = 32'h0;
        m_wrc  = 16'h0000;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        slv_bar_i = '0; slv_ce_i = 1'b0; slv_we_i = 1'b0;
        slv_adr_i = '0; slv_dat_i = '0; slv_sel_i = '0;
        dipsw = 8'h5A; btn = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (slv_dat_o !== 16'h0000 || led !== 8'hFF || segled !== 14'h3FFF) begin
            n_fail++;
            $display("FAIL reset_outputs dat=%h led=%h seg=%h required 0000/FF/3FFF",
                     slv_dat_o, led, segled);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_ram_fill();
        logic [15:0] e;
        for (int i = 0; i < 512; i++) begin
            do_cycle(7'h04, 1'b1, 1'b1, 19'(i), 16'($urandom), 2'b11, e);
        end
        for (int i = 0; i < 4; i++) begin
            int k = $urandom_range(0, 511);
            do_cycle(7'h04, 1'b0, 1'b0, 19'(k), 16'h0, 2'b00, e);
            n_checks++;
            if (slv_dat_o !== m_mem[k]) begin
                n_fail++;
                $display("FAIL ram_fill adr=%0d got=%h required=%h", k, slv_dat_o, m_mem[k]);
            end
        end
    endtask

    task automatic test_id();
        logic [15:0] e;
        do_cycle(7'h01, 1'b0, 1'b0, 19'd0, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h5043) begin
            n_fail++;
            $display("FAIL id_code got=%h required=5043", slv_dat_o);
        end
        do_cycle(7'h01, 1'b0, 1'b0, 19'd1, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h0001) begin
            n_fail++;
            $display("FAIL version got=%h required=0001", slv_dat_o);
        end
    endtask

    task automatic test_status();
        logic [15:0] e;
        dipsw = 8'($urandom);
        btn   = ~btn;
        repeat (3) do_cycle(7'h00, 1'b0, 1'b0, 19'd0, 16'h0, 2'b00, e);
        do_cycle(7'h01, 1'b0, 1'b0, 19'd2, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== {7'h00, btn, dipsw}) begin
            n_fail++;
            $display("FAIL status got=%h required=%h", slv_dat_o, {7'h00, btn, dipsw});
        end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] e;
        do_cycle(7'h01, 1'b1, 1'b1, 19'd3, 16'hA55A, 2'b10, e);
        do_cycle(7'h01, 1'b1, 1'b1, 19'd3, 16'h00C3, 2'b01, e);
        do_cycle(7'h01, 1'b0, 1'b0, 19'd3, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h00C3 || led !== 8'h3C) begin
            n_fail++;
            $display("FAIL byte_lanes reg3=%h led=%h required 00C3/3C", slv_dat_o, led);
        end
        do_cycle(7'h01, 1'b1, 1'b1, 19'd4, 16'hFFFF, 2'b00, e);
        do_cycle(7'h01, 1'b1, 1'b1, 19'd4, 16'hFE81, 2'b11, e);
        do_cycle(7'h01, 1'b0, 1'b0, 19'd4, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h3E81 || segled !== 14'h017E) begin
            n_fail++;
            $display("FAIL seg_reg reg4=%h seg=%h required 3E81/017E", slv_dat_o, segled);
        end
    endtask

    task automatic test_ram_priority();
        logic [15:0] e;
        do_cycle(7'h04, 1'b1, 1'b1, 19'h1FF, 16'h1234, 2'b11, e);
        do_cycle(7'h02, 1'b1, 1'b1, 19'h1FF, 16'hFFFF, 2'b11, e);
        do_cycle(7'h05, 1'b0, 1'b0, 19'h1FF, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL bar_priority got=%h required=0000", slv_dat_o);
        end
        do_cycle(7'h04, 1'b0, 1'b0, 19'h1FF, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h1234) begin
            n_fail++;
            $display("FAIL ram_read got=%h required=1234", slv_dat_o);
        end
        do_cycle(7'h04, 1'b0, 1'b0, 19'h3FF, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h1234) begin
            n_fail++;
            $display("FAIL ram_alias got=%h required=1234", slv_dat_o);
        end
        do_cycle(7'h01, 1'b0, 1'b0, 19'h7FF0, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h5043) begin
            n_fail++;
            $display("FAIL reg_alias got=%h required=5043", slv_dat_o);
        end
    endtask

    task automatic test_wr_count();
        logic [15:0] e;
        do_cycle(7'h01, 1'b1, 1'b1, 19'd8, 16'h0, 2'b11, e);
        for (int i = 0; i < 3; i++) begin
            do_cycle(7'h04, 1'b1, 1'b1, 19'(100 + i), 16'($urandom), 2'b01, e);
        end
        do_cycle(7'h04, 1'b1, 1'b1, 19'd200, 16'h1111, 2'b00, e);
        do_cycle(7'h01, 1'b0, 1'b0, 19'd8, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'd3) begin
            n_fail++;
            $display("FAIL wr_count_three got=%h required=0003", slv_dat_o);
        end
        // Clear write: reads the pre-write value in the same cycle.
        do_cycle(7'h01, 1'b1, 1'b1, 19'd8, 16'h0, 2'b10, e);
        n_checks++;
        if (slv_dat_o !== 16'd3) begin
            n_fail++;
            $display("FAIL read_during_write got=%h required=0003", slv_dat_o);
        end
        do_cycle(7'h01, 1'b0, 1'b0, 19'd8, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'd0) begin
            n_fail++;
            $display("FAIL wr_count_clear got=%h required=0000", slv_dat_o);
        end
    endtask

    task automatic test_random();
        logic [15:0] e;
        logic [6:0]  bar;
        logic [18:0] a;
        logic [1:0]  sel;
        for (int i = 0; i < 2000; i++) begin
            bar = 7'($urandom);
            a   = 19'($urandom);
            sel = 2'($urandom);
            // Keep snapshot/clear writes to a definite byte-enable case.
            if (bar[0] && (a[3:0] == 4'd6 || a[3:0] == 4'd8) && sel == 2'b00) sel = 2'b01;
            do_cycle(bar, 1'($urandom), 1'($urandom), a, 16'($urandom), sel, e);
            n_checks++;
            if (slv_dat_o !== e || led !== ~m_led || segled !== ~m_seg) begin
                n_fail++;
                $display("FAIL random i=%0d bar=%h adr=%h dat=%h/%h led=%h/%h seg=%h/%h", i,
                         bar, a, slv_dat_o, e, led, ~m_led, segled, ~m_seg);
            end
        end
    endtask

    task automatic test_snapshot_saturate();
        logic [15:0] e;
        int writes = 0;
        bit snapped = 0;
        for (int i = 0; i < 70000 && !(snapped && writes >= 65540); i++) begin
            if (m_cnt == 32'h0000_FFFF) begin
                do_cycle(7'h01, 1'b1, 1'b1, 19'd6, 16'($urandom), 2'b11, e);
                snapped = 1;
            end else begin
                do_cycle(7'h04, 1'b1, 1'b1, 19'($urandom), 16'($urandom), 2'b11, e);
            end
            writes++;
            n_checks++;
            if (slv_dat_o !== e) begin
                n_fail++;
                $display("FAIL saturate_loop i=%0d got=%h required=%h", i, slv_dat_o, e);
            end
        end
        do_cycle(7'h01, 1'b0, 1'b0, 19'd8, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wr_count_saturate got=%h required=FFFF", slv_dat_o);
        end
        repeat (2) begin
            do_cycle(7'h01, 1'b0, 1'b0, 19'd6, 16'h0, 2'b00, e);
            n_checks++;
            if (slv_dat_o !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL snapshot_lo got=%h required=FFFF", slv_dat_o);
            end
            do_cycle(7'h01, 1'b0, 1'b0, 19'd7, 16'h0, 2'b00, e);
            n_checks++;
            if (slv_dat_o !== 16'h0000) begin
                n_fail++;
                $display("FAIL snapshot_hi got=%h required=0000", slv_dat_o);
            end
            repeat (37) do_cycle(7'h00, 1'b0, 1'b0, 19'd0, 16'h0, 2'b00, e);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] e;
        do_cycle(7'h04, 1'b1, 1'b1, 19'h1FF, 16'h1234, 2'b11, e);
        do_cycle(7'h01, 1'b0, 1'b0, 19'd0, 16'h0, 2'b00, e);
        slv_bar_i = 7'h04; slv_ce_i = 1'b1; slv_we_i = 1'b1;
        slv_adr_i = 19'h1FF; slv_dat_i = 16'hBEEF; slv_sel_i = 2'b11;
        #2 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (slv_dat_o !== 16'h0000 || led !== 8'hFF || segled !== 14'h3FFF) begin
            n_fail++;
            $display("FAIL reset_async dat=%h led=%h seg=%h required 0000/FF/3FFF",
                     slv_dat_o, led, segled);
        end
        @(posedge clk);
        @(negedge clk);
        slv_ce_i = 1'b0; slv_we_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        model_reset();
        do_cycle(7'h04, 1'b0, 1'b0, 19'h1FF, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h1234) begin
            n_fail++;
            $display("FAIL ram_retained got=%h required=1234", slv_dat_o);
        end
        do_cycle(7'h01, 1'b0, 1'b0, 19'd8, 16'h0, 2'b00, e);
        n_checks++;
        if (slv_dat_o !== 16'h0000 || led !== 8'hFF) begin
            n_fail++;
            $display("FAIL wr_count_after_reset got=%h led=%h required 0000/FF", slv_dat_o, led);
        end
    endtask

    initial begin
        test_reset();
        test_ram_fill();
        test_id();
        test_status();
        test_byte_lanes();
        test_ram_priority();
        test_wr_count();
        test_random();
        test_snapshot_saturate();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
